delay_arbiter: RTL and testbench
================================

Name: delay_arbiter

Overview:
- Shares one prescaled down-counter between NREQ requesters (motor/encoder sequencers, servo timing, match timer).
- Each requester asks for a wait of N ticks. The block grants the counter round-robin, counts the delay, and signals completion.
- It sits between the control FSMs and the timing datapath, so each FSM no longer needs a private counter.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DBITS, 16, width of each requested delay in ticks.
- PRESCALE, 1, clk cycles per tick (>=1). PRESCALE=0 is illegal: print "delay_arbiter: invalid parameters" and call $finish(1) at elaboration.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  NREQ  per-requester request level; held high until done or until cancelled.
- delay  in  NREQ*DBITS  packed delays; requester i uses bits [i*DBITS +: DBITS]. Sampled only in LOAD.
- abort  in  1  synchronous cancel of the active wait.
- gnt  out  NREQ  one-hot grant; all zero when idle.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- busy  out  1  high in any state other than IDLE.
- cur_id  out  $clog2(NREQ)  index of the granted requester; holds its last value while idle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, done=0, busy=0, cur_id=0, rr pointer=0, remaining=0, prescaler=0.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If req!=0, pick the first set bit searching from the pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - Register the pick into cur_id and go to LOAD.
- LOAD (1 cycle):
  - gnt[cur_id]=1, busy=1.
  - remaining <= delay[cur_id], prescaler <= 0.
  - Delay 0 -> DONE next cycle; otherwise -> COUNT.
- COUNT:
  - prescaler counts 0..PRESCALE-1 and wraps; a tick occurs on the cycle prescaler==PRESCALE-1.
  - remaining decrements on each tick.
  - A tick with remaining==1 -> DONE.
  - COUNT lasts exactly delay*PRESCALE cycles.
- DONE (1 cycle):
  - done[cur_id]=1, gnt still high.
  - pointer <= cur_id+1 (mod NREQ); next state IDLE.
- Latency: LOAD in cycle L gives the done pulse in cycle L+1+delay*PRESCALE. gnt is high for delay*PRESCALE+2 cycles. Arbitration costs one IDLE cycle between consecutive grants.
- Cancel: req[cur_id] low, or abort high, while in LOAD or COUNT:
  - Next state is IDLE with no done pulse.
  - pointer <= cur_id+1.
  - abort has the same effect.
- abort in IDLE or DONE is ignored; a DONE pulse is never suppressed.
- req changes on non-granted lines never affect the active wait; they are only sampled in IDLE.
- Max delay (all ones) must not overflow: remaining is DBITS wide and is only decremented from a non-zero value.
- Asynchronous reset mid-COUNT returns all outputs to reset values immediately; the wait is lost.
- Requesters must drive a stable delay by LOAD; later changes are ignored.

Test Plan:
All scenarios use NREQ=4, DBITS=8, PRESCALE=2.
- Single request: req=0001, delay0=3 -> gnt=0001 for 8 cycles; done[0] pulses in cycle LOAD+7; busy low afterwards.
- Zero delay: req=0100, delay2=0 -> LOAD, then DONE next cycle; done[2] pulses 1 cycle after LOAD; no COUNT state.
- Round robin: req=1111 held, all delays=1 -> grant order 0,1,2,3,0; each gnt lasts 4 cycles, separated by one IDLE cycle.
- Cancel:
  - req=0010, delay1=10; drop req[1] 5 cycles into COUNT -> IDLE next cycle, no done pulse, pointer=2.
  - Repeat with abort=1 -> same result.
- Max delay with async reset: delay=255 -> done after 510 COUNT cycles. A second run with rst=0 pulsed mid-COUNT -> gnt=0, busy=0 without waiting for a clk edge.
- Simultaneous events: abort asserted in the DONE cycle -> done still pulses; a new req=1000 arriving during COUNT waits until after DONE.

Source files
------------

// File: rtl/delay_arbiter.sv
// delay_arbiter: one prescaled down-counter shared round-robin between NREQ
// requesters. A requester holds req high, gets a one-hot grant, and is told
// through a one-cycle done pulse that its requested number of ticks has passed.
module delay_arbiter #(
  parameter int NREQ     = 4,
  parameter int DBITS    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DBITS-1:0]    delay,
  input  logic                     abort,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_id
);

  localparam int ID_W = $clog2(NREQ);
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Refuse to build with an unusable configuration.
  generate
    if (PRESCALE < 1 || NREQ < 2 || NREQ > 16 || DBITS < 1) begin : g_bad_params
      $fatal(1, "delay_arbiter: invalid parameters");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   cur_id_reg, cur_id_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [DBITS-1:0]  rem_reg, rem_next;
  logic [PW-1:0]     presc_reg, presc_next;

  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic [DBITS-1:0]  sel_delay;
  logic [ID_W-1:0]   ptr_after;
  logic              cancel;
  logic              tick;

  // Index base+offset, wrapped into 0..NREQ-1 (offset is always < NREQ).
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return ID_W'(sum);
  endfunction

  // Round-robin search: walking offsets downward lets the smallest offset win.
  always_comb begin
    pick_id    = ptr_reg;
    pick_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_index(ptr_reg, k)]) begin
        pick_id    = rr_index(ptr_reg, k);
        pick_valid = 1'b1;
      end
    end
  end

  assign sel_delay = delay[int'(cur_id_reg)*DBITS +: DBITS];
  assign ptr_after = (cur_id_reg == ID_W'(NREQ - 1)) ? '0 : cur_id_reg + ID_W'(1);
  assign cancel    = abort || !req[cur_id_reg];
  assign tick      = (presc_reg == PW'(PRESCALE - 1));

  // Next-state and datapath updates; cancel outranks completion in LOAD/COUNT.
  always_comb begin
    state_next  = state_reg;
    cur_id_next = cur_id_reg;
    ptr_next    = ptr_reg;
    rem_next    = rem_reg;
    presc_next  = presc_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          cur_id_next = pick_id;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        if (cancel) begin
          ptr_next   = ptr_after;
          state_next = IDLE;
        end else begin
          rem_next   = sel_delay;
          presc_next = '0;
          state_next = (sel_delay == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (cancel) begin
          ptr_next   = ptr_after;
          state_next = IDLE;
        end else if (tick) begin
          presc_next = '0;
          if (rem_reg != '0) rem_next = rem_reg - DBITS'(1);
          if (rem_reg <= DBITS'(1)) state_next = DONE;
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end
      DONE: begin
        ptr_next   = ptr_after;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cur_id_reg <= '0;
      ptr_reg    <= '0;
      rem_reg    <= '0;
      presc_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cur_id_reg <= cur_id_next;
      ptr_reg    <= ptr_next;
      rem_reg    <= rem_next;
      presc_reg  <= presc_next;
    end
  end

  // Outputs decode from registers only, so reset clears them at once.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_out
      assign gnt[gi]  = (state_reg != IDLE) && (cur_id_reg == ID_W'(gi));
      assign done[gi] = (state_reg == DONE) && (cur_id_reg == ID_W'(gi));
    end
  endgenerate

  assign busy   = (state_reg != IDLE);
  assign cur_id = cur_id_reg;

endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: scoreboard bench. The driver issues request batches and
// pushes the expected grant episodes (id, grant length, done, idle gap);
// an independent monitor reconstructs episodes from gnt/done and compares.
module tb_delay_arbiter;
  localparam int NREQ     = 4;
  localparam int DBITS    = 8;
  localparam int PRESCALE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] delay = '0;
  logic        abort = 1'b0;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [1:0]  cur_id;

  delay_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .req(req), .delay(delay), .abort(abort),
    .gnt(gnt), .done(done), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int len; int dn; int gap; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] mask, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  int m_in = 0, m_cur = 0, m_len = 0, m_dn = 0, m_idle = 0, m_gap = 0, m_last = -1, m_id = 0;
  exp_t m_e;

  always @(negedge clk) begin
    if (!rst) begin
      m_in = 0; m_idle = 0; m_last = -1;
    end else begin
      check("busy", int'(busy), int'(gnt != 0));
      if (gnt != 0) begin
        check("gnt_onehot", int'($onehot(gnt)), 1);
        m_id = 0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) m_id = i;
        if (m_in == 0) begin
          m_in = 1; m_cur = m_id; m_len = 0; m_dn = 0; m_gap = m_idle; m_idle = 0;
        end else begin
          check("gnt_stable", m_id, m_cur);
        end
        m_len++;
        check("cur_id", int'(cur_id), m_id);
        if (done != 0) begin
          check("done_line", int'(done), int'(gnt));
          m_dn++;
        end
      end else begin
        check("done_idle", int'(done), 0);
        if (m_in != 0) begin
          m_in = 0;
          m_last = m_cur;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: id=%0d len=%0d with empty scoreboard", m_cur, m_len);
          end else begin
            m_e = sb.pop_front();
            $display("grant id=%0d len=%0d done=%0d gap=%0d (exp id=%0d len=%0d done=%0d)",
                     m_cur, m_len, m_dn, m_gap, m_e.id, m_e.len, m_e.dn);
            check("grant_id", m_cur, m_e.id);
            check("grant_len", m_len, m_e.len);
            check("done_count", m_dn, m_e.dn);
            if (m_e.gap >= 0) check("idle_gap", m_gap, m_e.gap);
          end
        end
        m_idle++;
        if (m_last >= 0) check("cur_id_hold", int'(cur_id), m_last);
      end
    end
  end

  // ---------------- driver ----------------
  // mode: 0 = normal, 1 = drop req of first grant at grant cycle cj,
  //       2 = abort at grant cycle cj. late bits are raised in the 2nd grant cycle.
  task automatic run_batch(input logic [3:0] m0, input logic [3:0] late,
                           input logic [31:0] dv, input int mode, input int cj);
    logic [3:0] rem;
    int first, c, g, n, started, budget, full;
    exp_t e;
    delay = dv;
    first = rr_pick(m0, model_ptr);
    if (mode != 0) begin
      full = int'(dv[first*8 +: 8]) * PRESCALE + 2;
      e.id = first; e.gap = -1;
      if (cj <= full - 1) begin e.len = cj; e.dn = 0; end
      else begin e.len = full; e.dn = 1; end
      sb.push_back(e);
      model_ptr = (first + 1) % NREQ;
    end else begin
      rem = m0 | late; c = first; g = -1;
      while (c >= 0) begin
        e.id = c; e.len = int'(dv[c*8 +: 8]) * PRESCALE + 2; e.dn = 1; e.gap = g;
        sb.push_back(e);
        rem[c] = 1'b0; model_ptr = (c + 1) % NREQ; g = 1;
        c = rr_pick(rem, model_ptr);
      end
    end
    req = m0; started = 0; n = 0;
    for (budget = 0; budget < 3000; budget++) begin
      @(negedge clk);
      if (started == 0 && gnt != 0) started = 1;
      if (started != 0) n++;
      req = req & ~done;
      if (late != 0 && n == 2) req = req | late;
      if (mode == 2 && abort) begin abort = 1'b0; req[first] = 1'b0; end
      if (mode != 0 && n == cj) begin
        if (mode == 1) req[first] = 1'b0;
        else abort = 1'b1;
      end
      if (started != 0 && req == 0 && !abort) break;
    end
    if (budget >= 3000) begin
      checks++; errors++;
      $display("FAIL batch_timeout: req=%b still pending", req);
      req = '0; abort = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  logic [3:0]  r_m0, r_late;
  logic [31:0] r_dv;
  int r_first, r_mode, r_cj, r_full, waited;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_id", int'(cur_id), 0);
    rst = 1'b1;
    @(negedge clk);

    // directed scenarios
    run_batch(4'b1111, 4'b0000, 32'h01010101, 0, 0);   // round robin 0,1,2,3
    run_batch(4'b0001, 4'b0000, 32'h00000003, 0, 0);   // single, 8-cycle grant
    run_batch(4'b0100, 4'b0000, 32'h00000000, 0, 0);   // zero delay
    run_batch(4'b0010, 4'b0000, 32'h00000A00, 1, 6);   // req drop 5 cycles into COUNT
    run_batch(4'b1111, 4'b0000, 32'h01010101, 0, 0);   // pointer now 2
    run_batch(4'b0010, 4'b0000, 32'h00000A00, 2, 6);   // abort 5 cycles into COUNT
    run_batch(4'b0001, 4'b0000, 32'h00000002, 2, 6);   // abort in DONE is ignored
    run_batch(4'b0001, 4'b1000, 32'h01000004, 0, 0);   // late req waits
    abort = 1'b1; @(negedge clk); abort = 1'b0;        // abort while idle
    run_batch(4'b0001, 4'b0000, 32'h000000FF, 0, 0);   // max delay

    // randomized batches
    for (int t = 0; t < 40; t++) begin
      r_dv = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
              8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
      r_mode = 0; r_cj = 0; r_late = '0;
      if ($urandom_range(0, 2) == 0) begin
        r_m0 = 4'b0001 << $urandom_range(0, 3);
        r_first = rr_pick(r_m0, model_ptr);
        r_full = int'(r_dv[r_first*8 +: 8]) * PRESCALE + 2;
        r_mode = $urandom_range(1, 2);
        r_cj = $urandom_range(1, r_full);
      end else begin
        r_m0 = 4'($urandom_range(1, 15));
        r_first = rr_pick(r_m0, model_ptr);
        if (r_dv[r_first*8 +: 8] != 0 && $urandom_range(0, 1) == 1)
          r_late = 4'($urandom_range(0, 15)) & ~r_m0;
      end
      if ($urandom_range(0, 3) == 0) begin abort = 1'b1; @(negedge clk); abort = 1'b0; end
      run_batch(r_m0, r_late, r_dv, r_mode, r_cj);
    end

    // asynchronous reset in the middle of a long wait
    delay = 32'h000000FF;
    req = 4'b0001;
    waited = 0;
    while (gnt == 0 && waited < 20) begin @(negedge clk); waited++; end
    check("rst_run_granted", int'(gnt), 1);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_cur_id", int'(cur_id), 0);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    run_batch(4'b1111, 4'b0000, 32'h00000000, 0, 0);   // pointer restarted at 0

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin @(negedge clk); waited++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d expected grants never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
